// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types for the load/store unit memory controller:
// funct3 encodings, FSM states and access-size helpers.
package lsu_mem_ctrl_pkg;

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;
  localparam logic [2:0] FN3_SB  = 3'b000;
  localparam logic [2:0] FN3_SH  = 3'b001;
  localparam logic [2:0] FN3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } lsu_state_t;

  function automatic logic [3:0] size_mask(
    input logic [2:0] f
  );
    case (f[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(
    input logic [2:0] f
  );
    case (f[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for one bus beat: enables, write data
// placement and the read-data contribution of that beat.
module lsu_lane_align #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      off,
  input  logic [3:0]      mask,
  input  logic            beat,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rd_part
);

  logic [4:0] sh_lo;
  logic [5:0] sh_hi;
  logic [2:0] roff;

  assign sh_lo = {off, 3'b000};
  assign sh_hi = 6'd32 - {1'b0, off, 3'b000};
  assign roff  = 3'd4 - {1'b0, off};

  // Second beat carries the bytes that spilled past the word end.
  always_comb begin
    be      = '0;
    wdata   = '0;
    rd_part = '0;
    if (!beat) begin
      be      = mask << off;
      wdata   = store_data << sh_lo;
      rd_part = rdata >> sh_lo;
    end else begin
      be      = mask >> roff;
      wdata   = store_data >> sh_hi;
      rd_part = rdata << sh_hi;
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: one or two word beats per request on a
// req/ack bus, with load reassembly and sign/zero extension.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MAX_BYTES = XLEN / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           fn3,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      store_data,
  output logic                 rsp_valid,
  output logic [XLEN-1:0]      rsp_data,
  output logic                 rsp_err,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [XLEN-1:0]      bus_addr,
  output logic [MAX_BYTES-1:0] bus_be,
  output logic [XLEN-1:0]      bus_wdata,
  input  logic [XLEN-1:0]      bus_rdata,
  input  logic                 bus_ack
);

  lsu_state_t state, state_nxt;

  logic [XLEN-1:0] a_addr;
  logic [XLEN-1:0] a_sd;
  logic [XLEN-1:0] raw;
  logic [2:0]      a_fn3;
  logic            a_ld;
  logic            a_we;
  logic            a_err;

  logic            accept;
  logic            ok_ld;
  logic            ok_st;
  logic            req_bad;
  logic [1:0]      off;
  logic [3:0]      mask;
  logic [2:0]      end_pos;
  logic            split;
  logic            busy;
  logic            beat1;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rd;
  logic [XLEN-1:0] ext;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  assign ok_ld = (fn3 == FN3_LB) || (fn3 == FN3_LH)
              || (fn3 == FN3_LW) || (fn3 == FN3_LBU)
              || (fn3 == FN3_LHU);
  assign ok_st = (fn3 == FN3_SB) || (fn3 == FN3_SH)
              || (fn3 == FN3_SW);

  assign req_bad = (is_load == is_store)
                || (is_load && !ok_ld)
                || (is_store && !ok_st);

  assign off     = a_addr[1:0];
  assign mask    = size_mask(a_fn3);
  assign end_pos = {1'b0, off} + size_bytes(a_fn3);
  assign split   = (end_pos > 3'd4);

  assign busy  = (state == ST_BEAT0) || (state == ST_BEAT1);
  assign beat1 = (state == ST_BEAT1);

  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .off        (off),
    .mask       (mask),
    .beat       (beat1),
    .store_data (a_sd),
    .rdata      (bus_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .rd_part    (al_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = req_bad ? ST_RESP : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (bus_ack) begin
          state_nxt = split ? ST_BEAT1 : ST_RESP;
        end
      end
      ST_BEAT1: begin
        if (bus_ack) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_addr <= '0;
      a_sd   <= '0;
      a_fn3  <= '0;
      a_ld   <= 1'b0;
      a_we   <= 1'b0;
      a_err  <= 1'b0;
      raw    <= '0;
    end else if (accept) begin
      a_addr <= addr;
      a_sd   <= store_data;
      a_fn3  <= fn3;
      a_ld   <= is_load;
      a_we   <= is_store;
      a_err  <= req_bad;
      raw    <= '0;
    end else if (busy && bus_ack && a_ld) begin
      raw <= beat1 ? (raw | al_rd) : al_rd;
    end
  end

  always_comb begin
    ext = raw;
    case (a_fn3)
      FN3_LB:  ext = {{24{raw[7]}}, raw[7:0]};
      FN3_LH:  ext = {{16{raw[15]}}, raw[15:0]};
      FN3_LBU: ext = {24'd0, raw[7:0]};
      FN3_LHU: ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  assign bus_req   = busy;
  assign bus_we    = busy && a_we;
  assign bus_be    = busy ? al_be : '0;
  assign bus_wdata = busy ? al_wdata : '0;
  assign bus_addr  = busy
                   ? ({a_addr[XLEN-1:2], 2'b00}
                      + {{(XLEN-3){1'b0}}, beat1, 2'b00})
                   : '0;

  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && a_err;
  assign rsp_data  = (rsp_valid && a_ld && !a_err) ? ext : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed vector bench for lsu_mem_ctrl with a scripted bus
// responder and a mid-transfer reset sequence.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  fn3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int total = 0;
  int bad = 0;

  lsu_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_load    (is_load),
    .is_store   (is_store),
    .fn3        (fn3),
    .addr       (addr),
    .store_data (store_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] ad;
    logic [31:0] sd;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          waits;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] rsp;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(
    input logic ld, input logic st, input logic [2:0] f3,
    input logic [31:0] ad, input logic [31:0] sd,
    input logic [31:0] rd0, input logic [31:0] rd1,
    input int waits, input int beats,
    input logic [31:0] a0, input logic [3:0] be0,
    input logic [31:0] wd0, input logic [31:0] a1,
    input logic [3:0] be1, input logic [31:0] wd1,
    input logic [31:0] rsp, input logic err
  );
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3;
    v.ad = ad; v.sd = sd; v.rd0 = rd0; v.rd1 = rd1;
    v.waits = waits; v.beats = beats;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0;
    v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    v.rsp = rsp; v.err = err;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int guard;
    int exp_lat;
    req_valid  = 1'b1;
    is_load    = v.ld;
    is_store   = v.st;
    fn3        = v.f3;
    addr       = v.ad;
    store_data = v.sd;
    chk($sformatf("v%0d_req_ready", idx), {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    is_load    = ~v.ld;
    is_store   = ~v.st;
    fn3        = ~v.f3;
    addr       = ~v.ad;
    store_data = ~v.sd;
    cyc = 1;
    for (int b = 0; b < v.beats; b++) begin
      for (int w = 0; w <= v.waits; w++) begin
        chk($sformatf("v%0d_b%0d_req", idx, b),
            {31'd0, bus_req}, 32'd1);
        chk($sformatf("v%0d_b%0d_we", idx, b),
            {31'd0, bus_we}, {31'd0, v.st});
        chk($sformatf("v%0d_b%0d_addr", idx, b),
            bus_addr, (b == 0) ? v.a0 : v.a1);
        chk($sformatf("v%0d_b%0d_be", idx, b),
            {28'd0, bus_be}, {28'd0, (b == 0) ? v.be0 : v.be1});
        chk($sformatf("v%0d_b%0d_wdata", idx, b),
            bus_wdata, (b == 0) ? v.wd0 : v.wd1);
        if (w == v.waits) begin
          bus_ack   = 1'b1;
          bus_rdata = (b == 0) ? v.rd0 : v.rd1;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
        end
        @(posedge clk); #1;
        cyc++;
      end
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(posedge clk); #1;
      cyc++;
      guard++;
    end
    exp_lat = 1 + v.beats * (v.waits + 1);
    chk($sformatf("v%0d_rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d_latency", idx), cyc, exp_lat);
    chk($sformatf("v%0d_rsp_busreq", idx), {31'd0, bus_req}, 32'd0);
    chk($sformatf("v%0d_rsp_data", idx), rsp_data, v.rsp);
    chk($sformatf("v%0d_rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.err});
    @(posedge clk); #1;
    chk($sformatf("v%0d_rsp_pulse", idx), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d_ready_back", idx), {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int quiet;
    vecs[0]  = mkv(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1,
                   32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(1, 0, 3'b000, 32'h203, 0, 32'h80112233, 0, 0, 1,
                   32'h200, 4'h8, 0, 0, 0, 0, 32'hFFFFFF80, 0);
    vecs[2]  = mkv(1, 0, 3'b100, 32'h203, 0, 32'h80112233, 0, 1, 1,
                   32'h200, 4'h8, 0, 0, 0, 0, 32'h00000080, 0);
    vecs[3]  = mkv(1, 0, 3'b010, 32'h302, 0, 32'hAABBCCDD,
                   32'h11223344, 3, 2, 32'h300, 4'hC, 0,
                   32'h304, 4'h3, 0, 32'h3344AABB, 0);
    vecs[4]  = mkv(0, 1, 3'b001, 32'h7, 32'h0000BEEF, 0, 0, 1, 2,
                   32'h4, 4'h8, 32'hEF000000, 32'h8, 4'h1,
                   32'h000000BE, 0, 0);
    vecs[5]  = mkv(1, 0, 3'b011, 32'h40, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 1);
    vecs[6]  = mkv(1, 1, 3'b010, 32'h40, 32'h5, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 1);
    vecs[7]  = mkv(0, 0, 3'b010, 32'h40, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 1);
    vecs[8]  = mkv(0, 1, 3'b011, 32'h40, 32'h7, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 1);
    vecs[9]  = mkv(1, 0, 3'b001, 32'h3, 0, 32'h12345678,
                   32'h9ABCDEF0, 1, 2, 32'h0, 4'h8, 0,
                   32'h4, 4'h1, 0, 32'hFFFFF012, 0);
    vecs[10] = mkv(1, 0, 3'b101, 32'h1, 0, 32'hAA8765BB, 0, 2, 1,
                   32'h0, 4'h6, 0, 0, 0, 0, 32'h00008765, 0);
    vecs[11] = mkv(1, 0, 3'b010, 32'hFFFFFFFE, 0, 32'h55667788,
                   32'h99AABBCC, 0, 2, 32'hFFFFFFFC, 4'hC, 0,
                   32'h0, 4'h3, 0, 32'hBBCC5566, 0);
    vecs[12] = mkv(0, 1, 3'b010, 32'h11, 32'h11223344, 0, 0, 2, 2,
                   32'h10, 4'hE, 32'h22334400, 32'h14, 4'h1,
                   32'h00000011, 0, 0);
    vecs[13] = mkv(0, 1, 3'b000, 32'h22, 32'h000000A5, 0, 0, 0, 1,
                   32'h20, 4'h4, 32'h00A50000, 0, 0, 0, 0, 0);
    vecs[14] = mkv(1, 0, 3'b001, 32'h40, 0, 32'h00008001, 0, 1, 1,
                   32'h40, 4'h3, 0, 0, 0, 0, 32'hFFFF8001, 0);
    vecs[15] = mkv(1, 0, 3'b110, 32'h40, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 1);

    rst        = 1'b1;
    req_valid  = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    fn3        = 3'b000;
    addr       = '0;
    store_data = '0;
    bus_rdata  = '0;
    bus_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i], i);
    end

    req_valid  = 1'b1;
    is_load    = 1'b1;
    is_store   = 1'b0;
    fn3        = 3'b010;
    addr       = 32'h302;
    store_data = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("rstmid_beat1_addr", bus_addr, 32'h304);
    chk("rstmid_beat1_req", {31'd0, bus_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstmid_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    quiet = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid || bus_req) quiet++;
      @(posedge clk); #1;
    end
    chk("rstmid_no_rsp", quiet, 0);
    run_vec(vecs[3], 100);
    run_vec(vecs[0], 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Sequences load/store requests from the execute stage onto a single word-wide memory bus with a req/ack handshake.
- Computes byte enables and lane shifts from the address offset.
- Splits misaligned accesses that cross a word boundary into two bus beats, then reassembles the load data and applies sign or zero extension.
- Sits between the core's memory stage and the data memory or bus interconnect; the core stalls on req_ready.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.
- MAX_BYTES, XLEN/8, number of byte lanes on the bus.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  controller accepts a request this cycle.
- is_load  in  1  request is a load.
- is_store  in  1  request is a store.
- fn3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- addr  in  XLEN  byte address.
- store_data  in  XLEN  store value, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  XLEN  extended load result; 0 for stores and errors.
- rsp_err  out  1  illegal fn3 or malformed request; valid with rsp_valid.
- bus_req  out  1  bus access request; held until bus_ack.
- bus_we  out  1  write when 1.
- bus_addr  out  XLEN  word-aligned address (bits [1:0] = 0).
- bus_be  out  MAX_BYTES  byte-lane enables.
- bus_wdata  out  XLEN  lane-shifted write data.
- bus_rdata  in  XLEN  read data; sampled in the bus_ack cycle.
- bus_ack  in  1  access complete this cycle.

Behaviour:
- Reset state: IDLE. All outputs are 0 except req_ready, which is 1. All internal registers are cleared.
- req_ready = (state == IDLE). A request is accepted on req_valid && req_ready. At acceptance, addr, fn3, is_load and store_data are captured.
- Size: 1, 2 or 4 bytes from fn3[1:0]. off = addr[1:0]. base mask = 'b1, 'b11 or 'b1111 by size.
- split = (off + size > 4).
- Illegal request, in any of these cases:
  - is_load and fn3 is 011, 110 or 111;
  - is_store and fn3 is not 000, 001 or 010;
  - is_load == is_store.
- On an illegal request: go directly to RESP with rsp_err = 1. No bus access is made.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE -> BEAT0 on a legal accepted request.
  - IDLE -> RESP on an illegal accepted request.
  - BEAT0 -> BEAT1 on bus_ack when split.
  - BEAT0 -> RESP on bus_ack when not split.
  - BEAT1 -> RESP on bus_ack.
  - RESP -> IDLE unconditionally.
- BEAT0 drive:
  - bus_addr = addr & ~3.
  - bus_be = (mask << off) truncated to 4 bits.
  - bus_wdata = store_data << 8*off.
- BEAT1 drive:
  - bus_addr = (addr & ~3) + 4; wrap-around at 2^32 is permitted.
  - bus_be = mask >> (4 - off).
  - bus_wdata = store_data >> 8*(4 - off).
- Bus handshake:
  - bus_req is 1 throughout BEAT0 and BEAT1.
  - bus_we = captured is_store.
  - All bus outputs are stable while waiting for bus_ack.
  - bus_ack outside BEAT0/BEAT1 is ignored.
- Load assembly:
  - On the BEAT0 ack: raw = bus_rdata >> 8*off.
  - On the BEAT1 ack: raw |= bus_rdata << 8*(4 - off).
  - In RESP, rsp_data is raw extended per fn3: LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW passes raw through.
- RESP: rsp_valid = 1 for exactly one cycle. req_ready = 0 in RESP, so back-to-back requests have one idle bubble.
- Latency, with N wait cycles per beat: aligned = 2 + N cycles from acceptance to rsp_valid; split = 3 + 2N cycles.
- Reset mid-operation: immediate return to IDLE. bus_req drops asynchronously and no rsp_valid is issued; the bus must tolerate an abandoned request.
- Inputs are sampled only at acceptance. Changes to them while busy have no effect.

Decomposition:
- Shared package:
  - fn3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the FSM state enum;
  - the size/mask function from fn3.
- One sub-module, lsu_lane_align, which is combinational:
  - inputs: off, mask, beat index;
  - outputs: bus_be, the shifted write data, and the shifted read contribution.
- Load extension stays inline in the controller.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, ack after 0 waits -> one beat: bus_addr=0x100, be=1111, wdata=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_err=0.
- LB addr=0x203, bus_rdata=0x80112233 -> be=1000; rsp_data=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- LW addr=0x302 (split); beat0 rdata=0xAABBCCDD, beat1 rdata=0x11223344 -> beats at 0x300 be=1100 and 0x304 be=0011; rsp_data=0x3344AABB. Bus outputs held through 3 wait cycles on each beat.
- SH addr=0x7, data=0x0000BEEF -> beat0 0x4 be=1000 wdata[31:24]=0xEF; beat1 0x8 be=0001 wdata[7:0]=0xBE.
- LW fn3=011, and a request with is_load=is_store=1 -> no bus_req; rsp_valid next cycle with rsp_err=1, rsp_data=0.
- rst asserted during a BEAT1 wait -> bus_req=0 and req_ready=1 immediately; no rsp_valid; next request runs normally.
